// File: rtl/dma_register_port.sv
// Program-register port of an 8237A-style DMA controller: decodes CPU I/O
// cycles, holds channel registers and merges end-of-transfer updates.
module dma_register_port (
    input  logic        clock,
    input  logic        reset,
    input  logic        nCS,
    input  logic        nIOR,
    input  logic        nIOW,
    input  logic        HLDA,
    input  logic [3:0]  ADDR,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [3:0]  dreq,
    input  logic        upd_valid,
    input  logic [1:0]  upd_ch,
    input  logic [15:0] upd_addr,
    input  logic [15:0] upd_count,
    input  logic        upd_tc,
    output logic [7:0]  command,
    output logic [23:0] mode,
    output logic [3:0]  mask,
    output logic [3:0]  req_reg,
    output logic [63:0] cur_addr,
    output logic [63:0] cur_count
);

    logic        acc;
    logic        wr_pend, rd_pend, wr_commit, rd_commit;
    logic [3:0]  wr_addr, rd_addr;
    logic [7:0]  wr_data;
    logic        bp;
    logic [3:0]  tc;
    logic [63:0] base_addr, base_count;

    logic        bp_n;
    logic [3:0]  tc_n, mask_n, req_n;
    logic [7:0]  cmd_n;
    logic [23:0] mode_n;
    logic [63:0] ba_n, bc_n, ca_n, cc_n;
    logic        autoinit;
    logic [5:0]  upd_ofs, wr_ofs, rd_ofs;

    assign acc       = !nCS && !HLDA;
    assign data_oe   = acc && !nIOR;
    assign wr_commit = wr_pend && nIOW;
    assign rd_commit = rd_pend && nIOR;
    assign upd_ofs   = {upd_ch, 4'b0000};
    assign wr_ofs    = {wr_addr[2:1], bp, 3'b000};
    assign rd_ofs    = {ADDR[2:1], bp, 3'b000};

    always_comb begin
        autoinit = 1'b0;
        for (int c = 0; c < 4; c++)
            if (upd_ch == c[1:0])
                autoinit = mode[6*c+2];
    end

    always_comb begin
        data_out = 8'h00;
        if (data_oe) begin
            if (!ADDR[3])
                data_out = ADDR[0] ? cur_count[rd_ofs +: 8] : cur_addr[rd_ofs +: 8];
            else if (ADDR == 4'h8)
                data_out = {dreq | req_reg, tc};
        end
    end

    // Ordering below encodes priority: status-read clear, then core update,
    // then the CPU write, so later assignments win.
    always_comb begin
        bp_n   = bp;
        tc_n   = tc;
        mask_n = mask;
        req_n  = req_reg;
        cmd_n  = command;
        mode_n = mode;
        ba_n   = base_addr;
        bc_n   = base_count;
        ca_n   = cur_addr;
        cc_n   = cur_count;
        if (rd_commit) begin
            if (!rd_addr[3])
                bp_n = ~bp_n;
            else if (rd_addr == 4'h8)
                tc_n = 4'h0;
        end
        if (upd_valid) begin
            ca_n[upd_ofs +: 16] = upd_addr;
            cc_n[upd_ofs +: 16] = upd_count;
            if (upd_tc) begin
                tc_n[upd_ch]  = 1'b1;
                req_n[upd_ch] = 1'b0;
                if (autoinit) begin
                    ca_n[upd_ofs +: 16] = base_addr[upd_ofs +: 16];
                    cc_n[upd_ofs +: 16] = base_count[upd_ofs +: 16];
                end else begin
                    mask_n[upd_ch] = 1'b1;
                end
            end
        end
        if (wr_commit) begin
            if (!wr_addr[3]) begin
                if (wr_addr[0]) begin
                    bc_n[wr_ofs +: 8] = wr_data;
                    cc_n[wr_ofs +: 8] = wr_data;
                end else begin
                    ba_n[wr_ofs +: 8] = wr_data;
                    ca_n[wr_ofs +: 8] = wr_data;
                end
                bp_n = ~bp_n;
            end else begin
                case (wr_addr[2:0])
                    3'd0: cmd_n = wr_data;
                    3'd1: req_n[wr_data[1:0]] = wr_data[2];
                    3'd2: mask_n[wr_data[1:0]] = wr_data[2];
                    3'd3: begin
                        for (int c = 0; c < 4; c++)
                            if (wr_data[1:0] == c[1:0])
                                mode_n[6*c +: 6] = wr_data[7:2];
                    end
                    3'd4: bp_n = 1'b0;
                    3'd5: begin
                        cmd_n  = 8'h00;
                        tc_n   = 4'h0;
                        req_n  = 4'h0;
                        mask_n = 4'hF;
                        bp_n   = 1'b0;
                    end
                    3'd6: mask_n = 4'h0;
                    default: mask_n = wr_data[3:0];
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_pend    <= 1'b0;
            rd_pend    <= 1'b0;
            wr_addr    <= 4'h0;
            rd_addr    <= 4'h0;
            wr_data    <= 8'h00;
            bp         <= 1'b0;
            tc         <= 4'h0;
            mask       <= 4'hF;
            req_reg    <= 4'h0;
            command    <= 8'h00;
            mode       <= 24'h0;
            base_addr  <= 64'h0;
            base_count <= 64'h0;
            cur_addr   <= 64'h0;
            cur_count  <= 64'h0;
        end else begin
            if (acc && !nIOW) begin
                wr_pend <= 1'b1;
                wr_addr <= ADDR;
                wr_data <= data_in;
            end else if (nIOW) begin
                wr_pend <= 1'b0;
            end
            if (acc && !nIOR) begin
                rd_pend <= 1'b1;
                rd_addr <= ADDR;
            end else if (nIOR) begin
                rd_pend <= 1'b0;
            end
            bp         <= bp_n;
            tc         <= tc_n;
            mask       <= mask_n;
            req_reg    <= req_n;
            command    <= cmd_n;
            mode       <= mode_n;
            base_addr  <= ba_n;
            base_count <= bc_n;
            cur_addr   <= ca_n;
            cur_count  <= cc_n;
        end
    end

endmodule

// File: doc/dma_register_port.md
# dma_register_port

Slave-side responder for the 8237A system bus, i.e. the DMA controller's program-register port. It decodes the CPU's I/O read and write cycles (nCS, nIOR, nIOW, ADDR[3:0], DATA) while the DMA controller is idle, and holds the command, mode, mask, request, status and per-channel base/current address and count registers. It supplies these registers to the DMA timing core and accepts the core's end-of-transfer updates.

## Interface
- No parameters. Four channels, 16-bit address and count, 8-bit data.
- clock  input  1  system clock; all bus inputs are sampled on posedge.
- reset  input  1  asynchronous, active-high.
- nCS  input  1  chip select, active low.
- nIOR  input  1  I/O read strobe, active low.
- nIOW  input  1  I/O write strobe, active low.
- HLDA  input  1  hold acknowledge. While it is 1, the slave port ignores all accesses.
- ADDR  input  4  register select (ADDR[3:0] of the bus).
- data_in  input  8  write data from DATA.
- data_out  output  8  read data.
- data_oe  output  1  DATA drive enable.
- dreq  input  4  hardware requests, for status only.
- upd_valid  input  1  core update strobe.
- upd_ch  input  2  channel of the update.
- upd_addr, upd_count  input  16 each  new current address and count.
- upd_tc  input  1  terminal count reached.
- command  output  8  command register.
- mode  output  24  mode[6c+5:6c] = channel c mode bits [7:2].
- mask  output  4  mask bits.
- req_reg  output  4  software request bits.
- cur_addr, cur_count  output  64 each  channel c occupies [16c+15:16c].

## Operation
- Access qualifier: acc = !nCS && !HLDA.
- Register map (W = write, R = read):
  - 0/2/4/6: W sets both base and current address of channel ADDR[2:1]; R returns current address.
  - 1/3/5/7: the same, for count.
  - 8: W command, R status.
  - 9: W request. data[1:0] selects the channel, data[2] is the bit value.
  - A: W single mask. Same data format as 9.
  - B: W mode. data[1:0] selects the channel, data[7:2] is stored.
  - C: W clears the byte pointer.
  - D: W is master clear, R returns 8'h00.
  - E: W clears mask to 0.
  - F: W sets mask to data[3:0].
- Reads of write-only addresses 9, A, B, C, E, F return 8'h00 and have no side effects.
- Byte pointer (bp):
  - Selects the low byte (0) or high byte (1) for addresses 0–7.
  - Toggles at the commit of every read or write to 0–7.
  - Cleared by reset, by a write to C and by master clear.
- Status register: [7:4] = dreq | req_reg, [3:0] = TC flags. Committing a status read clears TC[3:0].
- Master clear and reset:
  - command = 0, TC = 0, req_reg = 0, mask = 4'hF, bp = 0.
  - Reset additionally zeroes mode, base registers and current registers. Master clear leaves these unchanged.
- Core update, applied when upd_valid is 1:
  - Load the current registers of upd_ch from upd_addr and upd_count.
  - If upd_tc is 1:
    - set TC[upd_ch] and clear req_reg[upd_ch];
    - if autoinit (mode bit 4, i.e. mode[6·upd_ch+2]) is 1, reload the current registers from base instead of from upd_*;
    - otherwise set mask[upd_ch].
- Priority rules:
  - A CPU write committing to the same register in the same cycle wins over the core update.
  - A TC set wins over a TC clear from a status read in the same cycle.

## Timing
- data_oe = acc && !nIOR, combinational.
- data_out is combinational from ADDR, bp and the registers, with no wait states. It is 8'h00 when data_oe = 0.
- Write path:
  - Each posedge with acc && !nIOW sets wr_pend and latches ADDR and data_in. The last low-sampled cycle wins.
  - The first posedge that samples nIOW = 1 with wr_pend set commits the latched write and clears wr_pend.
  - The new value is visible on the outputs in the cycle after that edge.
  - On a T1–T4 cycle with nIOW low in T2–T3, the write commits at the end of T4 using the T3 data.
- Read path: works the same way with rd_pend. Side effects (bp toggle, TC clear) happen on the trailing edge of nIOR only, so the data read stays stable for the whole strobe.
- Strobe held low for N cycles: exactly one commit.
- nCS rising while the strobe is still low: the pending access still commits on the strobe's rising edge.
- Reset asserted mid-access: all outputs and the pending flags return to their reset values immediately. No commit occurs for the aborted strobe.
- Reset values: data_out = 0, data_oe = 0, command = 0, mode = 0, mask = 4'hF, req_reg = 0, cur_addr = 0, cur_count = 0.

## Test plan
- Reset, then read 8: data_out = 8'h00 while strobed, mask = 4'hF, bp = 0.
- Write 8'h34 then 8'h12 to address 2, then read address 2 twice → 8'h34 then 8'h12; cur_addr[31:16] = 16'h1234.
- Write to address 0 (toggles bp), write C, write 8'hAA to address 1 → the low byte of ch0 count = 8'hAA.
- Write mode 8'h12 (ch2, autoinit), base count 16'h0005, then upd_valid with upd_ch = 2, upd_tc = 1 → cur_count ch2 = 5, status = 8'h04, mask[2] unchanged. A following status read clears TC.
- Same as above with mode 8'h02 → mask[2] = 1, req_reg[2] = 0.
- HLDA = 1 during a write to F → no change to mask, data_oe stays 0. Assert reset with nIOW low on address 8 → command = 0, with no commit after reset is released.
